fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the core's decode/execute pipeline. It issues word reads on the core's read bus (raddr/rsel/din/rdata) and buffers returned words in a small prefetch FIFO. It presents the buffered instructions, each tagged with its PC, to the core over a valid/ready handshake. It flushes and restarts on a redirect from the core (jump/branch).

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 46 ++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, FIFO entry layout, bus constants.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_REQ   = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP   = 32'h0000_0013;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush discards everything, including a same-cycle push/pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t head_o,
   output logic [AW:0]  count_o,
   output logic         full_o,
   output logic         empty_o
);

   logic [AW:0]  wr_q, rd_q;
   fetch_entry_t mem_q [DEPTH];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i && !full_o) begin
            mem_q[wr_q[AW-1:0]] <= wdata_i;
            wr_q                <= wr_q + 1'b1;
         end
         if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
      end
   end

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign count_o = wr_q - rd_q;
   assign full_o  = (count_o == (AW + 1)'(DEPTH));
   assign empty_o = (wr_q == rd_q);
   assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding read bus master feeding a prefetch FIFO.
// Optional bus-timeout detection is enabled with `define FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int unsigned DEPTH          = 4,
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] raddr,
   output logic        rsel,
   input  logic        din,
   input  logic [31:0] rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        fetch_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_params
      $error("fetch_unit: unsupported DEPTH/TIMEOUT_CYCLES");
   end

   fetch_state_e state_q;
   logic         rsel_q;
   logic [31:0]  raddr_q;
   logic [31:0]  fetch_pc_q;

   logic         push, pop;
   logic         fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]  cnt_after;
   logic         room_after;
   logic         req_blocked;
   fetch_entry_t head;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic          err_q;
   logic [TW-1:0] to_cnt_q;
   assign req_blocked = err_q;
   assign fetch_err   = err_q;
`else
   assign req_blocked = 1'b0;
   assign fetch_err   = 1'b0;
`endif

   assign push = (state_q == FS_REQ) && din && !redirect;
   assign pop  = inst_valid && inst_ready && !redirect;

   // Occupancy after this edge; the issued request must still have a slot to land in.
   always_comb begin
      cnt_after  = {1'b0, fifo_count} + (CW + 1)'(1) - (CW + 1)'(pop);
      room_after = (cnt_after < (CW + 1)'(DEPTH));
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk),
      .rst_i   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .wdata_i ('{pc: raddr_q, inst: rdata}),
      .head_o  (head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= FS_IDLE;
         rsel_q     <= 1'b0;
         raddr_q    <= RESET_PC;
         fetch_pc_q <= RESET_PC;
`ifdef FETCH_TIMEOUT_EN
         err_q      <= 1'b0;
         to_cnt_q   <= '0;
`endif
      end else if (redirect) begin
         fetch_pc_q <= word_align(redirect_pc);
`ifdef FETCH_TIMEOUT_EN
         err_q      <= 1'b0;
         to_cnt_q   <= '0;
`endif
         if ((state_q == FS_IDLE) || din) begin
            state_q <= FS_REQ;
            rsel_q  <= 1'b1;
            raddr_q <= word_align(redirect_pc);
         end else begin
            state_q <= FS_DRAIN;
         end
      end else begin
         case (state_q)
            FS_IDLE: begin
               if (!fifo_full && !req_blocked) begin
                  state_q <= FS_REQ;
                  rsel_q  <= 1'b1;
                  raddr_q <= fetch_pc_q;
               end
            end
            FS_REQ: begin
               if (din) begin
                  fetch_pc_q <= raddr_q + WORD_BYTES;
                  if (room_after) begin
                     raddr_q <= raddr_q + WORD_BYTES;
                  end else begin
                     state_q <= FS_IDLE;
                     rsel_q  <= 1'b0;
                  end
               end
            end
            FS_DRAIN: begin
               if (din) begin
                  state_q <= FS_REQ;
                  raddr_q <= fetch_pc_q;
               end
            end
            default: begin
               state_q <= FS_IDLE;
               rsel_q  <= 1'b0;
            end
         endcase
`ifdef FETCH_TIMEOUT_EN
         if (rsel_q && !din) begin
            if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               err_q    <= 1'b1;
               rsel_q   <= 1'b0;
               state_q  <= FS_IDLE;
               to_cnt_q <= '0;
            end else begin
               to_cnt_q <= to_cnt_q + TW'(1);
            end
         end else begin
            to_cnt_q <= '0;
         end
`endif
      end
   end

   assign rsel       = rsel_q;
   assign raddr      = raddr_q;
   assign inst_valid = !fifo_empty;
   assign inst_data  = head.inst;
   assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus hand sequences for latency, reset and timeout.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk, reset;
   logic [31:0] raddr, rdata, inst_data, inst_pc, redirect_pc;
   logic        rsel, din, inst_valid, inst_ready, redirect, fetch_err;

   int ntests = 0;
   int nfail  = 0;

   bit mem_en  = 0;
   int mem_lat = 0;
   int wcnt    = 0;

   logic [31:0] req_q[$];
   logic [31:0] pop_pc_q[$];
   logic [31:0] pop_dat_q[$];

   typedef struct {
      logic        din;
      logic        rdy;
      logic        redir;
      logic [31:0] rpc;
      logic        e_rsel;
      logic        chk_addr;
      logic [31:0] e_raddr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .raddr(raddr), .rsel(rsel), .din(din), .rdata(rdata),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
      .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] memw(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   function automatic vec_t v(input logic d, input logic r, input logic rd, input logic [31:0] rpc,
                              input logic es, input logic ca, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
      vec_t t;
      t.din = d; t.rdy = r; t.redir = rd; t.rpc = rpc;
      t.e_rsel = es; t.chk_addr = ca; t.e_raddr = ea; t.e_valid = ev; t.e_pc = ep;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Record the handshake that the coming edge will perform, then step to the next negedge.
   task automatic cyc();
      if (inst_valid && inst_ready && !redirect && !reset) begin
         pop_pc_q.push_back(inst_pc);
         pop_dat_q.push_back(inst_data);
      end
      @(negedge clk);
      din      = 1'b0;
      rdata    = INST_NOP;
      redirect = 1'b0;
      if (mem_en && rsel && !reset) begin
         if (wcnt >= mem_lat) begin
            din   = 1'b1;
            rdata = memw(raddr);
            req_q.push_back(raddr);
            wcnt  = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_en = 0; wcnt = 0;
      din = 0; rdata = INST_NOP; inst_ready = 0; redirect = 0; redirect_pc = '0;
      repeat (2) @(negedge clk);
      chk("rst.rsel", {31'd0, rsel}, 32'd0);
      chk("rst.raddr", raddr, 32'h0000_0000);
      chk("rst.valid", {31'd0, inst_valid}, 32'd0);
      chk("rst.data", inst_data, 32'd0);
      chk("rst.pc", inst_pc, 32'd0);
      chk("rst.err", {31'd0, fetch_err}, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      vec_t tbl[$];
      bit seen, drop;

      // din / ready / redirect / rpc | rsel / chk_addr / raddr / valid / pc
      tbl.push_back(v(0,0,0,0,            1,1,32'h0,        0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h4,        1,32'h0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h8,        1,32'h0));
      tbl.push_back(v(1,0,0,0,            1,1,32'hC,        1,32'h0));
      tbl.push_back(v(1,0,0,0,            0,0,32'h0,        1,32'h0));
      tbl.push_back(v(0,0,0,0,            0,0,32'h0,        1,32'h0));
      tbl.push_back(v(0,1,0,0,            0,0,32'h0,        1,32'h4));
      tbl.push_back(v(0,1,0,0,            1,1,32'h10,       1,32'h8));
      tbl.push_back(v(0,1,0,0,            1,1,32'h10,       1,32'hC));
      tbl.push_back(v(1,1,0,0,            1,1,32'h14,       1,32'h10));
      tbl.push_back(v(0,1,0,0,            1,1,32'h14,       0,0));
      tbl.push_back(v(0,0,1,32'h103,      1,1,32'h14,       0,0));
      tbl.push_back(v(0,0,0,0,            1,1,32'h14,       0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h100,      0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h104,      1,32'h100));
      tbl.push_back(v(1,1,1,32'h200,      1,1,32'h200,      0,0));
      tbl.push_back(v(0,0,0,0,            1,1,32'h200,      0,0));
      tbl.push_back(v(0,0,1,32'hFFFF_FFFE,1,1,32'h200,      0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'hFFFF_FFFC,0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h0,        1,32'hFFFF_FFFC));
      tbl.push_back(v(1,1,0,0,            1,1,32'h4,        1,32'h0));
      tbl.push_back(v(0,1,0,0,            1,1,32'h4,        0,0));
      tbl.push_back(v(0,0,1,32'h300,      1,1,32'h4,        0,0));
      tbl.push_back(v(0,0,1,32'h400,      1,1,32'h4,        0,0));
      tbl.push_back(v(1,0,0,0,            1,1,32'h400,      0,0));
      tbl.push_back(v(0,0,0,0,            1,1,32'h400,      0,0));

      do_reset();
      foreach (tbl[i]) begin
         din         = tbl[i].din;
         rdata       = tbl[i].din ? memw(raddr) : INST_NOP;
         inst_ready  = tbl[i].rdy;
         redirect    = tbl[i].redir;
         redirect_pc = tbl[i].rpc;
         cyc();
         chk($sformatf("row%0d.rsel", i), {31'd0, rsel}, {31'd0, tbl[i].e_rsel});
         if (tbl[i].chk_addr) chk($sformatf("row%0d.raddr", i), raddr, tbl[i].e_raddr);
         chk($sformatf("row%0d.valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_valid});
         if (tbl[i].e_valid) begin
            chk($sformatf("row%0d.pc", i), inst_pc, tbl[i].e_pc);
            chk($sformatf("row%0d.data", i), inst_data, memw(tbl[i].e_pc));
         end
      end

      // Two-cycle memory latency with a consuming core: sequential requests, rsel never drops.
      do_reset();
      req_q.delete(); pop_pc_q.delete(); pop_dat_q.delete();
      mem_en = 1; mem_lat = 2; inst_ready = 1;
      seen = 0; drop = 0;
      repeat (40) begin
         cyc();
         if (rsel) seen = 1;
         else if (seen) drop = 1;
      end
      chk("lat2.nreq", {31'd0, req_q.size() >= 4}, 32'd1);
      chk("lat2.npop", {31'd0, pop_pc_q.size() >= 4}, 32'd1);
      chk("lat2.rsel_drop", {31'd0, drop}, 32'd0);
      if (req_q.size() >= 4 && pop_pc_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("lat2.req%0d", i), req_q[i], 32'(i * 4));
            chk($sformatf("lat2.pop_pc%0d", i), pop_pc_q[i], 32'(i * 4));
            chk($sformatf("lat2.pop_dat%0d", i), pop_dat_q[i], memw(32'(i * 4)));
         end
      end

      // Asynchronous reset in the middle of a transfer, then a stray din.
      do_reset();
      mem_en = 1; mem_lat = 0; inst_ready = 0;
      cyc(); cyc();
      chk("arst.pre_valid", {31'd0, inst_valid}, 32'd1);
      chk("arst.pre_rsel", {31'd0, rsel}, 32'd1);
      mem_en = 0; din = 0;
      #2 reset = 1'b1;
      #1;
      chk("arst.rsel", {31'd0, rsel}, 32'd0);
      chk("arst.valid", {31'd0, inst_valid}, 32'd0);
      chk("arst.raddr", raddr, 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      din   = 1'b1;
      rdata = 32'h1234_5678;
      cyc();
      chk("arst.rel_rsel", {31'd0, rsel}, 32'd1);
      chk("arst.rel_raddr", raddr, 32'h0);
      chk("arst.stray_valid", {31'd0, inst_valid}, 32'd0);
      cyc();
      chk("arst.stray_valid2", {31'd0, inst_valid}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
      do_reset();
      cyc();
      chk("to.rsel_start", {31'd0, rsel}, 32'd1);
      repeat (7) cyc();
      chk("to.rsel_7", {31'd0, rsel}, 32'd1);
      chk("to.err_7", {31'd0, fetch_err}, 32'd0);
      cyc();
      chk("to.rsel_8", {31'd0, rsel}, 32'd0);
      chk("to.err_8", {31'd0, fetch_err}, 32'd1);
      repeat (3) cyc();
      chk("to.rsel_idle", {31'd0, rsel}, 32'd0);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0040;
      cyc();
      chk("to.redir_rsel", {31'd0, rsel}, 32'd1);
      chk("to.redir_raddr", raddr, 32'h0000_0040);
      chk("to.redir_err", {31'd0, fetch_err}, 32'd0);
`else
      do_reset();
      repeat (20) cyc();
      chk("hang.rsel", {31'd0, rsel}, 32'd1);
      chk("hang.raddr", raddr, 32'h0);
      chk("hang.err", {31'd0, fetch_err}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
